// File: rtl/ud_monitor_pkg.sv
// Shared types and constants for the up/down counter monitor.
package ud_monitor_pkg;

  // Monitor FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Classification of one sample-to-sample step.
  typedef enum logic [1:0] {
    CL_UP   = 2'd0,
    CL_DN   = 2'd1,
    CL_SAME = 2'd2,
    CL_BAD  = 2'd3
  } step_cls_t;

  // Segment patterns, bit6=g ... bit0=a, active-high.
  localparam logic [6:0] SEG_IDLE = 7'b0000000;
  localparam logic [6:0] SEG_HOLD = 7'b1000000;  // '-'
  localparam logic [6:0] SEG_UP   = 7'b0111110;  // 'U'
  localparam logic [6:0] SEG_DOWN = 7'b1011110;  // 'd'
  localparam logic [6:0] SEG_ERR  = 7'b1111001;  // 'E'

  // Modulo-16 delta to step class; wrap-around falls out of the 4-bit math.
  function automatic step_cls_t classify(input logic [3:0] delta);
    step_cls_t cls;
    case (delta)
      4'd1:    cls = CL_UP;
      4'd15:   cls = CL_DN;
      4'd0:    cls = CL_SAME;
      default: cls = CL_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ud_seg_enc.sv
// Maps the monitor state onto a 7-segment glyph and a digit-enable.
module ud_seg_enc
  import ud_monitor_pkg::*;
(
  input  state_t     i_state,
  output logic [6:0] o_seg,
  output logic       o_digit
);

  // State to glyph lookup; digit lights whenever any segment is on.
  always_comb begin
    o_seg = SEG_IDLE;
    case (i_state)
      ST_IDLE: o_seg = SEG_IDLE;
      ST_HOLD: o_seg = SEG_HOLD;
      ST_UP:   o_seg = SEG_UP;
      ST_DOWN: o_seg = SEG_DOWN;
      ST_ERR:  o_seg = SEG_ERR;
      default: o_seg = SEG_IDLE;
    endcase
    o_digit = |o_seg;
  end

endmodule

// File: rtl/ud_monitor.sv
// Watches a 4-bit up/down counter and reports a debounced direction,
// illegal jumps, a saturating step count and a 7-segment glyph.
module ud_monitor
  import ud_monitor_pkg::*;
#(
  parameter int CONFIRM = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  input  logic       cnt_vld,
  output logic       dir_up,
  output logic       dir_dn,
  output logic       err,
  output logic [7:0] steps,
  output logic [6:0] seg,
  output logic       digit
);

  localparam logic [2:0] CONFIRM_W = 3'(CONFIRM);

  state_t      r_state;
  logic [3:0]  r_prev;
  logic [2:0]  r_run;
  logic        r_run_up;
  logic [7:0]  r_steps;
  logic        r_dir_up;
  logic        r_dir_dn;
  logic        r_err;
  logic [6:0]  r_seg;
  logic        r_digit;

  logic [3:0]  w_delta;
  step_cls_t   w_cls;
  logic        w_is_up;
  state_t      w_state_nxt;
  logic [2:0]  w_run_nxt;
  logic        w_run_up_nxt;
  logic [7:0]  w_steps_nxt;
  logic [6:0]  w_seg;
  logic        w_digit;

  assign w_delta = cnt_in - r_prev;
  assign w_cls   = classify(w_delta);
  assign w_is_up = (w_cls == CL_UP);

  // Next-state, run-length and step-count logic; everything holds unless a sample is valid.
  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_run_up_nxt = r_run_up;
    w_steps_nxt  = r_steps;
    if (cnt_vld) begin
      if (r_state == ST_IDLE) begin
        // First sample only primes prev.
        w_state_nxt = ST_HOLD;
        w_run_nxt   = 3'd0;
      end else begin
        case (w_cls)
          CL_UP, CL_DN: begin
            if ((r_run != 3'd0) && (r_run_up == w_is_up)) begin
              w_run_nxt = (r_run == 3'd7) ? 3'd7 : r_run + 3'd1;
            end else begin
              w_run_nxt = 3'd1;
            end
            w_run_up_nxt = w_is_up;
            if (r_steps != 8'hFF) begin
              w_steps_nxt = r_steps + 8'd1;
            end else begin
              w_steps_nxt = r_steps;
            end
            if (w_run_nxt >= CONFIRM_W) begin
              w_state_nxt = w_is_up ? ST_UP : ST_DOWN;
            end else begin
              w_state_nxt = r_state;
            end
          end
          CL_SAME: begin
            w_run_nxt = 3'd0;
            if ((r_state == ST_UP) || (r_state == ST_DOWN)) begin
              w_state_nxt = ST_HOLD;
            end else begin
              w_state_nxt = r_state;
            end
          end
          CL_BAD: begin
            w_run_nxt   = 3'd0;
            w_state_nxt = ST_ERR;
          end
          default: begin
            w_state_nxt = r_state;
          end
        endcase
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Glyph is encoded from the next state so the registered seg lands with the state.
  ud_seg_enc u_seg_enc (
    .i_state (w_state_nxt),
    .o_seg   (w_seg),
    .o_digit (w_digit)
  );

  // State and registered outputs; reset wins over a simultaneous valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_prev   <= 4'd0;
      r_run    <= 3'd0;
      r_run_up <= 1'b0;
      r_steps  <= 8'd0;
      r_dir_up <= 1'b0;
      r_dir_dn <= 1'b0;
      r_err    <= 1'b0;
      r_seg    <= 7'd0;
      r_digit  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= cnt_vld ? cnt_in : r_prev;
      r_run    <= w_run_nxt;
      r_run_up <= w_run_up_nxt;
      r_steps  <= w_steps_nxt;
      r_dir_up <= (w_state_nxt == ST_UP);
      r_dir_dn <= (w_state_nxt == ST_DOWN);
      r_err    <= (w_state_nxt == ST_ERR);
      r_seg    <= w_seg;
      r_digit  <= w_digit;
    end
  end

  assign dir_up = r_dir_up;
  assign dir_dn = r_dir_dn;
  assign err    = r_err;
  assign steps  = r_steps;
  assign seg    = r_seg;
  assign digit  = r_digit;

endmodule
